// File: rtl/mem_port_arbiter.sv
// Single memory-port arbiter between instruction fetch and load/store.
// Data wins by default; a saturating starvation counter forces a fetch win.
module mem_port_arbiter #(
  parameter int XLEN       = 32,
  parameter int MAX_STARVE = 4
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic              if_req_i,
  input  logic [XLEN-1:0]   if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [XLEN-1:0]   if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [XLEN/8-1:0] d_be_i,
  input  logic [XLEN-1:0]   d_addr_i,
  input  logic [XLEN-1:0]   d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [XLEN-1:0]   d_rdata_o,
  output logic              m_req_o,
  output logic              m_we_o,
  output logic [XLEN/8-1:0] m_be_o,
  output logic [XLEN-1:0]   m_addr_o,
  output logic [XLEN-1:0]   m_wdata_o,
  input  logic              m_gnt_i,
  input  logic [XLEN-1:0]   m_rdata_i
);

  localparam logic [3:0] MAX_STARVE_C = 4'(MAX_STARVE);

  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       tag_valid_q, tag_valid_d;
  logic       tag_fetch_q, tag_fetch_d;
  logic       fetch_win_s;
  logic       data_win_s;

  // Winner selection, memory-side mux and same-cycle grants
  always_comb begin
    fetch_win_s = if_req_i && (!d_req_i || (starve_cnt_q == MAX_STARVE_C));
    data_win_s  = d_req_i && !fetch_win_s;
    m_req_o     = 1'b0;
    m_we_o      = 1'b0;
    m_be_o      = {(XLEN/8){1'b0}};
    m_addr_o    = {XLEN{1'b0}};
    m_wdata_o   = {XLEN{1'b0}};
    if (fetch_win_s) begin
      m_req_o  = 1'b1;
      m_be_o   = {(XLEN/8){1'b1}};
      m_addr_o = if_addr_i;
    end else if (data_win_s) begin
      m_req_o   = 1'b1;
      m_we_o    = d_we_i;
      m_be_o    = d_be_i;
      m_addr_o  = d_addr_i;
      m_wdata_o = d_wdata_i;
    end else begin
      m_req_o = 1'b0;
    end
    if_gnt_o = fetch_win_s && m_gnt_i;
    d_gnt_o  = data_win_s && m_gnt_i;
  end

  // Starvation counter and read-owner tag next state
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!if_req_i || if_gnt_o) begin
      starve_cnt_d = 4'd0;
    end else if (m_gnt_i && (starve_cnt_q != MAX_STARVE_C)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
    tag_valid_d = if_gnt_o || (d_gnt_o && !d_we_i);
    tag_fetch_d = if_gnt_o;
  end

  // State flops; reset drops any in-flight response
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      starve_cnt_q <= 4'd0;
      tag_valid_q  <= 1'b0;
      tag_fetch_q  <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      tag_valid_q  <= tag_valid_d;
      tag_fetch_q  <= tag_fetch_d;
    end
  end

  // Response routing to the tag owner; non-owner data forced to zero
  always_comb begin
    if_rvalid_o = tag_valid_q && tag_fetch_q;
    d_rvalid_o  = tag_valid_q && !tag_fetch_q;
    if_rdata_o  = if_rvalid_o ? m_rdata_i : {XLEN{1'b0}};
    d_rdata_o   = d_rvalid_o ? m_rdata_i : {XLEN{1'b0}};
  end

endmodule
